// File: rtl/lfsr_rand_gen.sv
// Purpose : maximal-length Fibonacci LFSR random source; serial bit each enabled
//           step, OUT_BITS consecutive bits packed into a valid/ready word.
// Latency : RAND_STATE updates on the stepping edge; a word appears on the edge
//           of its OUT_BITS-th step (collector -> output register, no bubble).
// Backpressure: one word buffered in the collector; when both the collector and
//           the output register are full the LFSR freezes and STALL=1.
// Ports   : RAND_CLK/RAND_RST clock and async active-high reset; RAND_EN step
//           enable; SEED_LOAD/SEED_IN seed reload (0 -> DEFAULT_SEED);
//           RAND_OUT serial bit (state MSB); RAND_STATE LFSR register;
//           WORD_OUT/WORD_VALID/WORD_READY packed word handshake; STALL frozen.
module lfsr_rand_gen #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned OUT_BITS     = 8,
    parameter logic [31:0] DEFAULT_SEED = 32'd1
) (
    input  logic                RAND_CLK,
    input  logic                RAND_RST,
    input  logic                RAND_EN,
    input  logic                SEED_LOAD,
    input  logic [WIDTH-1:0]    SEED_IN,
    output logic                RAND_OUT,
    output logic [WIDTH-1:0]    RAND_STATE,
    output logic [OUT_BITS-1:0] WORD_OUT,
    output logic                WORD_VALID,
    input  logic                WORD_READY,
    output logic                STALL
);

    // Tap masks: bit n-1 set for each 1-indexed tap n of the maximal polynomial.
    localparam logic [31:0] TAP_MASK32 =
        (WIDTH == 8)  ? 32'h0000_00B8 :   // 8,6,5,4
        (WIDTH == 16) ? 32'h0000_D008 :   // 16,15,13,4
        (WIDTH == 24) ? 32'h00E1_0000 :   // 24,23,22,17
                        32'h8020_0003;    // 32,22,2,1
    localparam logic [WIDTH-1:0] TAP_MASK  = TAP_MASK32[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_DFLT = DEFAULT_SEED[WIDTH-1:0];
    localparam int unsigned      CNT_W     = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OUT_BITS - 1);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;

    generate
        if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 24 || WIDTH == 32)) begin : g_bad_width
            $error("lfsr_rand_gen: WIDTH must be 8, 16, 24 or 32");
        end
        if (OUT_BITS < 1 || OUT_BITS > WIDTH) begin : g_bad_out_bits
            $error("lfsr_rand_gen: OUT_BITS must be in 1..WIDTH");
        end
        if (SEED_DFLT == '0) begin : g_bad_seed
            $error("lfsr_rand_gen: DEFAULT_SEED truncated to WIDTH must be nonzero");
        end
    endgenerate

    logic [WIDTH-1:0]    lfsr_q;
    logic [WIDTH-1:0]    lfsr_step;
    logic [WIDTH-1:0]    seed_val;
    logic                fb;
    logic [OUT_BITS-1:0] col_q;
    logic [OUT_BITS-1:0] col_shift;
    logic [CNT_W-1:0]    cnt_q;
    logic [0:0]          fsm_q;
    logic [OUT_BITS-1:0] word_q;
    logic                valid_q;
    logic                step;
    logic                word_done;
    logic                out_free;
    logic                xfer;

    assign fb        = ^(lfsr_q & TAP_MASK);
    assign lfsr_step = {lfsr_q[WIDTH-2:0], fb};
    // A zero seed would lock the LFSR at zero forever, so substitute the default.
    assign seed_val  = (SEED_IN == '0) ? SEED_DFLT : SEED_IN;

    // The pre-step MSB (the serial bit currently shown) enters the collector LSB.
    generate
        if (OUT_BITS == 1) begin : g_col_one
            assign col_shift = lfsr_q[WIDTH-1];
        end else begin : g_col_many
            assign col_shift = {col_q[OUT_BITS-2:0], lfsr_q[WIDTH-1]};
        end
    endgenerate

    assign step      = RAND_EN && (fsm_q == ST_FILL) && !SEED_LOAD;
    assign word_done = step && (cnt_q == CNT_LAST);
    assign out_free  = !valid_q || WORD_READY;
    assign xfer      = valid_q && WORD_READY;

    always_ff @(posedge RAND_CLK or posedge RAND_RST) begin
        if (RAND_RST) begin
            lfsr_q  <= SEED_DFLT;
            col_q   <= '0;
            cnt_q   <= '0;
            fsm_q   <= ST_FILL;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            // Generator side: seed reload, stall release, or a normal step.
            if (SEED_LOAD) begin
                lfsr_q <= seed_val;
                col_q  <= '0;
                cnt_q  <= '0;
                fsm_q  <= ST_FILL;
            end else if (fsm_q == ST_FULL) begin
                if (WORD_READY) begin
                    col_q <= '0;
                    fsm_q <= ST_FILL;
                end
            end else if (step) begin
                lfsr_q <= lfsr_step;
                if (word_done) begin
                    cnt_q <= '0;
                    if (out_free) begin
                        col_q <= '0;
                    end else begin
                        // Output register still occupied: park the word and freeze.
                        col_q <= col_shift;
                        fsm_q <= ST_FULL;
                    end
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    col_q <= col_shift;
                end
            end

            // Output register. A seed load never touches the word itself, but a
            // handshake completing on that edge still retires it so it is not
            // delivered twice.
            if (!SEED_LOAD && (fsm_q == ST_FULL) && WORD_READY) begin
                word_q  <= col_q;
                valid_q <= 1'b1;
            end else if (word_done && out_free) begin
                word_q  <= col_shift;
                valid_q <= 1'b1;
            end else if (xfer) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign RAND_STATE = lfsr_q;
    assign RAND_OUT   = lfsr_q[WIDTH-1];
    assign WORD_OUT   = word_q;
    assign WORD_VALID = valid_q;
    assign STALL      = (fsm_q == ST_FULL);

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Directed bench for lfsr_rand_gen: an 8-bit instance exercises sequence,
// packing, backpressure, seed reload and reset; a 16-bit instance runs a period.
module tb_lfsr_rand_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en8, ld8, rdy8, out8, wv8, stall8;
    logic [7:0]  seed8, st8, wo8;
    logic        en16, ld16, rdy16, out16, wv16, stall16;
    logic [15:0] seed16, st16;
    logic [7:0]  wo16;

    lfsr_rand_gen #(.WIDTH(8), .OUT_BITS(8), .DEFAULT_SEED(32'd1)) u8 (
        .RAND_CLK(clk), .RAND_RST(rst), .RAND_EN(en8), .SEED_LOAD(ld8),
        .SEED_IN(seed8), .RAND_OUT(out8), .RAND_STATE(st8), .WORD_OUT(wo8),
        .WORD_VALID(wv8), .WORD_READY(rdy8), .STALL(stall8)
    );

    lfsr_rand_gen #(.WIDTH(16), .OUT_BITS(8), .DEFAULT_SEED(32'd1)) u16 (
        .RAND_CLK(clk), .RAND_RST(rst), .RAND_EN(en16), .SEED_LOAD(ld16),
        .SEED_IN(seed16), .RAND_OUT(out16), .RAND_STATE(st16), .WORD_OUT(wo16),
        .WORD_VALID(wv16), .WORD_READY(rdy16), .STALL(stall16)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  m8;
    logic [7:0]  bb;
    int          nb;
    logic [7:0]  sb[$];
    logic [7:0]  exp_seq [7];
    logic [15:0] m16, bb16, lastw16;
    int          nb16;
    bit          zero_seen, early_ret, model_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] nxt8(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [15:0] nxt16(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
    endfunction

    // One clock of the 8-bit instance. 'stepped' says whether this edge should
    // advance the LFSR; completed 8-bit words go to the scoreboard and are
    // checked when the DUT hands them over (WORD_VALID && WORD_READY at the edge).
    task automatic cyc(input logic en, input logic ld, input logic [7:0] seed,
                       input logic rdy, input bit stepped);
        en8 = en; ld8 = ld; seed8 = seed; rdy8 = rdy;
        if (wv8 && rdy) begin
            chk("sb_has_word", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) chk("word_out", 32'(wo8), 32'(sb.pop_front()));
        end
        @(posedge clk); #1;
        if (ld) begin
            m8 = (seed == 8'h00) ? 8'h01 : seed;
            bb = 8'h00;
            nb = 0;
        end else if (stepped) begin
            bb = {bb[6:0], m8[7]};
            nb++;
            m8 = nxt8(m8);
            if (nb == 8) begin
                sb.push_back(bb);
                nb = 0;
            end
        end
        chk("rand_state", 32'(st8), 32'(m8));
        chk("rand_out", 32'(out8), 32'(m8[7]));
    endtask

    initial begin
        rst = 1'b1;
        en8 = 0; ld8 = 0; seed8 = 0; rdy8 = 0;
        en16 = 0; ld16 = 0; seed16 = 0; rdy16 = 1;
        m8 = 8'h01; bb = 0; nb = 0;
        exp_seq = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};

        #12;
        chk("rst_state8", 32'(st8), 32'h01);
        chk("rst_valid", 32'(wv8), 32'd0);
        chk("rst_stall", 32'(stall8), 32'd0);
        chk("rst_word", 32'(wo8), 32'd0);
        chk("rst_state16", 32'(st16), 32'h0001);
        rst = 1'b0;

        // Sequence and packing with the consumer always ready.
        cyc(1, 1, 8'h01, 1, 0);
        for (int k = 1; k <= 16; k++) begin
            cyc(1, 0, 8'h00, 1, 1);
            if (k <= 7) chk("seq_tbl", 32'(st8), 32'(exp_seq[k-1]));
            if (k == 7) chk("msb_first_one", 32'(out8), 32'd1);
            if (k == 8) chk("first_word", 32'(wo8), 32'h01);
            chk("valid_pattern", 32'(wv8), 32'(k % 8 == 0));
        end
        cyc(0, 0, 8'h00, 1, 0);
        chk("valid_drop", 32'(wv8), 32'd0);

        // Backpressure: consumer stalled, collector fills, LFSR freezes.
        cyc(1, 1, 8'h01, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            cyc(1, 0, 8'h00, 0, 1);
            if (k == 8) chk("bp_first_word", 32'(wo8), 32'h01);
        end
        chk("bp_stall", 32'(stall8), 32'd1);
        chk("bp_valid", 32'(wv8), 32'd1);
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 8'h00, 0, 0);
            chk("bp_stall_hold", 32'(stall8), 32'd1);
            chk("bp_word_hold", 32'(wo8), 32'h01);
        end
        cyc(1, 0, 8'h00, 1, 0);
        chk("bp_release_stall", 32'(stall8), 32'd0);
        chk("bp_release_valid", 32'(wv8), 32'd1);
        chk("bp_second_word", 32'(wo8), 32'(sb[0]));
        cyc(1, 0, 8'h00, 0, 1);

        // Seed reload mid-word with a pending output word.
        cyc(1, 0, 8'h00, 0, 1);
        cyc(1, 0, 8'h00, 0, 1);
        cyc(1, 1, 8'h5A, 0, 0);
        chk("seed_5a", 32'(st8), 32'h5A);
        chk("seed_keep_word", 32'(wo8), 32'(sb[0]));
        chk("seed_keep_valid", 32'(wv8), 32'd1);
        cyc(1, 1, 8'h00, 0, 0);
        chk("seed_zero_dflt", 32'(st8), 32'h01);
        for (int k = 0; k < 8; k++) cyc(1, 0, 8'h00, 0, 1);
        chk("seed_full_stall", 32'(stall8), 32'd1);
        chk("seed_pending_word", 32'(wo8), 32'(sb[0]));
        chk("seed_sb_depth", 32'(sb.size()), 32'd2);
        cyc(1, 0, 8'h00, 1, 0);
        chk("fresh_word", 32'(wo8), 32'h01);
        cyc(0, 0, 8'h00, 1, 0);
        chk("drain_valid", 32'(wv8), 32'd0);
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);

        // Asynchronous reset mid-stall, between clock edges.
        cyc(1, 1, 8'h33, 0, 0);
        for (int k = 0; k < 16; k++) cyc(1, 0, 8'h00, 0, 1);
        chk("pre_rst_stall", 32'(stall8), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_state", 32'(st8), 32'h01);
        chk("arst_valid", 32'(wv8), 32'd0);
        chk("arst_stall", 32'(stall8), 32'd0);
        chk("arst_word", 32'(wo8), 32'd0);
        sb.delete();
        nb = 0; bb = 0; m8 = 8'h01;
        @(posedge clk); #1;
        chk("arst_hold", 32'(st8), 32'h01);
        rst = 1'b0;

        // Full period of the 8-bit LFSR, words streamed through the scoreboard.
        cyc(1, 1, 8'h01, 1, 0);
        zero_seen = 0; early_ret = 0;
        for (int k = 1; k <= 255; k++) begin
            cyc(1, 0, 8'h00, 1, 1);
            if (st8 == 8'h00) zero_seen = 1;
            if (st8 == 8'h01 && k < 255) early_ret = 1;
        end
        chk("p8_end", 32'(st8), 32'h01);
        chk("p8_zero_seen", 32'(zero_seen), 32'd0);
        chk("p8_early_return", 32'(early_ret), 32'd0);
        chk("p8_sb_empty", 32'(sb.size()), 32'd0);
        en8 = 0;

        // Full period of the 16-bit LFSR.
        ld16 = 1; seed16 = 16'h0001; en16 = 1;
        @(posedge clk); #1;
        ld16 = 0;
        chk("p16_seed", 32'(st16), 32'h0001);
        m16 = 16'h0001; bb16 = 0; nb16 = 0; lastw16 = 0;
        zero_seen = 0; early_ret = 0; model_bad = 0;
        for (int k = 1; k <= 65535; k++) begin
            bb16 = {bb16[14:0], m16[15]};
            nb16++;
            if (nb16 == 8) begin
                lastw16 = {8'h00, bb16[7:0]};
                nb16 = 0;
            end
            m16 = nxt16(m16);
            @(posedge clk); #1;
            if (st16 !== m16) model_bad = 1;
            if (st16 == 16'h0000) zero_seen = 1;
            if (st16 == 16'h0001 && k < 65535) early_ret = 1;
        end
        en16 = 0;
        chk("p16_end", 32'(st16), 32'h0001);
        chk("p16_zero_seen", 32'(zero_seen), 32'd0);
        chk("p16_early_return", 32'(early_ret), 32'd0);
        chk("p16_model", 32'(model_bad), 32'd0);
        chk("p16_rand_out", 32'(out16), 32'(m16[15]));
        chk("p16_last_word", 32'(wo16), 32'(lastw16[7:0]));
        chk("p16_valid", 32'(wv16), 32'd0);
        chk("p16_stall", 32'(stall16), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
